// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and NOP bubbles.
// Optional performance counters are enabled by defining STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding equals the beat count, so occupancy doubles as the FSM state debug view.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q, beat_data;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q, beat_ctrl;
  logic              push, pop;
  logic              load_main, load_skid, main_from_skid;

  // Handshake: a beat moves on a port in any cycle where its valid and ready are both high.
  assign in_ready  = (state_q != FULL) & ~bubble;
  assign out_valid = (state_q != EMPTY);
  assign push      = (in_valid & in_ready) | (bubble & (state_q != FULL));
  assign pop       = out_valid & out_ready;
  assign beat_data = bubble ? '0 : in_data;
  assign beat_ctrl = bubble ? NOP_CTRL : in_ctrl;
  assign occupancy = state_q;
  assign out_data  = (state_q == EMPTY) ? '0 : main_data_q;
  assign out_ctrl  = (state_q == EMPTY) ? NOP_CTRL : main_ctrl_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      main_data_q <= '0;
      main_ctrl_q <= NOP_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
    end else begin
      if (load_main) begin
        main_data_q <= beat_data;
        main_ctrl_q <= beat_ctrl;
      end else if (main_from_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= beat_data;
        skid_ctrl_q <= beat_ctrl;
      end
    end
  end

`ifdef STAGE_PERF_EN
  logic stall_inc, bubble_inc, flush_inc;
  // A bubble that coincides with a flush is never stored, so it is not counted.
  assign stall_inc  = out_valid & ~out_ready;
  assign bubble_inc = bubble & (state_q != FULL) & ~flush;
  assign flush_inc  = flush & (state_q != EMPTY);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1))   stall_cnt  <= stall_cnt + 1'b1;
      if (bubble_inc && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1))   flush_cnt  <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam logic [CTRL_W-1:0] NOP = 16'hC3A5;
  localparam int CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;
`ifdef STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              Clk, Clr;
  logic              in_valid, in_ready, bubble, flush, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [DATA_W+CTRL_W-1:0] exp_q[$];
  int held = 0;
  int exp_cnt = 0;
  int m_stall = 0, m_bubble = 0, m_flush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus plus the model's view of what the next edge does
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic b, input logic f, input logic r, output logic acc);
    int pop;
    @(posedge Clk); #1;
    in_valid = v; in_data = d; in_ctrl = c; bubble = b; flush = f; out_ready = r;
    exp_cnt = held;
    pop = (held > 0 && r) ? 1 : 0;
    acc = v && !b && held < 2;
    if (f) begin
      for (int i = 0; i < held - pop; i++) void'(exp_q.pop_back());
      held = 0;
    end else begin
      held = held - pop;
      if (b && exp_cnt < 2) begin
        exp_q.push_back({{DATA_W{1'b0}}, NOP});
        held++;
      end else if (acc) begin
        exp_q.push_back({d, c});
        held++;
      end
    end
  endtask

  task automatic idle(input logic r);
    logic acc;
    step(1'b0, '0, '0, 1'b0, 1'b0, r, acc);
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    logic [DATA_W+CTRL_W-1:0] e;
    if (!Clr) begin
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      check("occupancy", occupancy, exp_cnt);
      check("out_valid", out_valid, exp_cnt != 0);
      check("in_ready", in_ready, (exp_cnt < 2) && !bubble);
      if (exp_cnt == 0) begin
        check("empty_data", out_data, 0);
        check("empty_ctrl", out_ctrl, NOP);
      end
      check("stall_cnt", stall_cnt, PERF ? m_stall : 0);
      check("bubble_cnt", bubble_cnt, PERF ? m_bubble : 0);
      check("flush_cnt", flush_cnt, PERF ? m_flush : 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e[DATA_W+CTRL_W-1:CTRL_W]);
          check("beat_ctrl", out_ctrl, e[CTRL_W-1:0]);
        end
      end
      if (exp_cnt > 0 && !out_ready && m_stall < MAXC) m_stall++;
      if (bubble && !flush && exp_cnt < 2 && m_bubble < MAXC) m_bubble++;
      if (flush && exp_cnt > 0 && m_flush < MAXC) m_flush++;
    end
  end

  initial begin
    logic acc;
    logic [DATA_W-1:0] cd;
    logic [CTRL_W-1:0] cc;
    int n;
    Clr = 1'b0; in_valid = 0; in_data = '0; in_ctrl = '0; bubble = 0; flush = 0; out_ready = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, NOP);
    check("rst_occupancy", occupancy, 0);
    check("rst_counters", {stall_cnt, bubble_cnt, flush_cnt}, 0);
    @(posedge Clk); #1; Clr = 1'b1;

    // streaming
    step(1, 32'h11, 16'h1, 0, 0, 1, acc);
    step(1, 32'h22, 16'h2, 0, 0, 1, acc);
    step(1, 32'h33, 16'h3, 0, 0, 1, acc);
    idle(1); idle(1);

    // backpressure: A, B fill the stage, C waits upstream
    step(1, 32'hA, 16'hA, 0, 0, 0, acc);
    step(1, 32'hB, 16'hB, 0, 0, 0, acc);
    step(1, 32'hC, 16'hC, 0, 0, 0, acc);
    check("bp_c_held", acc, 0);
    n = 0;
    do begin
      step(1, 32'hC, 16'hC, 0, 0, 1, acc);
      n++;
    end while (!acc && n < 8);
    check("bp_c_accepted", acc, 1);
    idle(1); idle(1); idle(1);

    // bubble while upstream beat waits
    step(1, 32'h44, 16'h4, 1, 0, 1, acc);
    check("bubble_not_consumed", acc, 0);
    step(1, 32'h44, 16'h4, 0, 0, 1, acc);
    idle(1); idle(1);

    // flush from FULL with a concurrent upstream beat
    step(1, 32'h55, 16'h5, 0, 0, 0, acc);
    step(1, 32'h66, 16'h6, 0, 0, 0, acc);
    step(1, 32'h77, 16'h7, 0, 1, 0, acc);
    idle(1);
    // flush and bubble together, then flush of an empty stage
    step(0, '0, '0, 1, 1, 1, acc);
    step(0, '0, '0, 0, 1, 1, acc);
    idle(1);

    // stall run long enough to saturate a narrow counter
    step(1, 32'h88, 16'h8, 0, 0, 0, acc);
    repeat (5) idle(0);
    idle(1); idle(1);

    // asynchronous reset while FULL
    step(1, 32'h99, 16'h9, 0, 0, 0, acc);
    step(1, 32'hAA, 16'hA, 0, 0, 0, acc);
    @(posedge Clk); #3;
    in_valid = 0; bubble = 0; flush = 0; out_ready = 0;
    Clr = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_ctrl", out_ctrl, NOP);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_counters", {stall_cnt, bubble_cnt, flush_cnt}, 0);
    exp_q.delete(); held = 0; exp_cnt = 0;
    @(posedge Clk); #1; Clr = 1'b1;
    step(1, 32'hBB, 16'hB, 0, 0, 1, acc);
    step(1, 32'hCC, 16'hC, 0, 0, 1, acc);
    idle(1);

    // random traffic
    cd = $urandom(); cc = 16'($urandom());
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, cd, cc, $urandom_range(0, 9) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7, acc);
      if (acc) begin
        cd = $urandom(); cc = 16'($urandom());
      end
    end

    // drain with a bounded budget
    n = 0;
    while (held != 0 && n < 10) begin
      idle(1);
      n++;
    end
    check("drain_timeout", held, 0);
    idle(1);
    @(posedge Clk); #1;
    check("drain_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
